grid_sampler: RTL and testbench

//  Downstream of the mouse/draw datapath. Converts each painted screen coordinate

---
 rtl/grid_sampler.sv | 146 ++++++++++++++
 tb/tb_grid_sampler.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/grid_sampler.sv
// grid_sampler: maps painted screen points inside the drawing box onto a 14x14
// binary bitmap, holds it, and streams it out one cell per valid/ready beat.
// Ports:
//   CLOCK_50   in   system clock, rising edge
//   resetn     in   asynchronous active-low reset
//   paint      in   pulse: set the cell under (px,py)
//   px, py     in   9-bit screen coordinate of the paint point
//   clear      in   pulse: zero the whole bitmap (wins over start/paint)
//   start      in   pulse: stream the bitmap out
//   out_ready  in   consumer accepts the current beat
//   out_valid  out  out_pixel/out_index/out_last are valid
//   out_pixel  out  cell value, row-major order
//   out_index  out  cell index row*COLS+col
//   out_last   out  high with out_valid on the final cell
//   busy       out  FSM is not idle
//   cell_count out  number of cells currently set
module grid_sampler #(
    parameter logic [8:0] XMIN   = 9'd89,
    parameter logic [8:0] YMIN   = 9'd33,
    parameter logic [8:0] CELL_W = 9'd10,
    parameter logic [8:0] CELL_H = 9'd14,
    parameter int         COLS   = 14,
    parameter int         ROWS   = 14
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic       paint,
    input  logic [8:0] px,
    input  logic [8:0] py,
    input  logic       clear,
    input  logic       start,
    input  logic       out_ready,
    output logic       out_valid,
    output logic       out_pixel,
    output logic [7:0] out_index,
    output logic       out_last,
    output logic       busy,
    output logic [7:0] cell_count
);
    localparam int         NCELL = COLS * ROWS;
    localparam logic [7:0] LAST  = 8'(NCELL - 1);
    localparam logic [8:0] XMAX  = XMIN + 9'(COLS) * CELL_W - 9'd1;
    localparam logic [8:0] YMAX  = YMIN + 9'(ROWS) * CELL_H - 9'd1;

    typedef enum logic [2:0] {IDLE, MAP, WRITE, CLEAR, STREAM} state_t;

    state_t     state, state_nx;
    logic       mem [NCELL];
    logic [7:0] ptr, idx, next_index;
    logic [8:0] rx, ry;
    logic [3:0] cx, cy;
    logic       in_box, map_done, beat;

    assign in_box     = px >= XMIN && px <= XMAX && py >= YMIN && py <= YMAX;
    assign map_done   = rx < CELL_W && ry < CELL_H;
    assign idx        = {4'd0, cy} * 8'(COLS) + {4'd0, cx};
    assign next_index = out_index + 8'd1;
    assign beat       = out_valid && out_ready;
    assign busy       = state != IDLE;

    always_ff @(posedge CLOCK_50 or negedge resetn)
        if (!resetn) state <= CLEAR;
        else         state <= state_nx;

    // clear pre-empts every state, including an in-progress sweep (which restarts)
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = clear ? CLEAR : start ? STREAM : (paint && in_box) ? MAP : IDLE;
            MAP:     state_nx = clear ? CLEAR : map_done ? WRITE : MAP;
            WRITE:   state_nx = clear ? CLEAR : IDLE;
            CLEAR:   state_nx = (!clear && ptr == LAST) ? IDLE : CLEAR;
            STREAM:  state_nx = clear ? CLEAR : (beat && out_index == LAST) ? IDLE : STREAM;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge resetn)
        if (!resetn) begin
            ptr        <= 8'd0;
            cell_count <= 8'd0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            out_index  <= 8'd0;
            out_pixel  <= 1'b0;
            rx         <= 9'd0;
            ry         <= 9'd0;
            cx         <= 4'd0;
            cy         <= 4'd0;
        end else if (clear) begin
            ptr        <= 8'd0;
            cell_count <= 8'd0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
        end else begin
            case (state)
                CLEAR: ptr <= (ptr == LAST) ? 8'd0 : ptr + 8'd1;
                IDLE:
                    if (start) begin
                        out_valid <= 1'b1;
                        out_index <= 8'd0;
                        out_last  <= 1'b0;
                        out_pixel <= mem[0];
                    end else if (paint && in_box) begin
                        rx <= px - XMIN;
                        ry <= py - YMIN;
                        cx <= 4'd0;
                        cy <= 4'd0;
                    end
                // repeated subtraction replaces a divider; x and y run in parallel
                MAP: begin
                    if (rx >= CELL_W) begin
                        rx <= rx - CELL_W;
                        cx <= cx + 4'd1;
                    end
                    if (ry >= CELL_H) begin
                        ry <= ry - CELL_H;
                        cy <= cy + 4'd1;
                    end
                end
                WRITE:
                    if (!mem[idx] && cell_count != 8'(NCELL))
                        cell_count <= cell_count + 8'd1;
                // next cell is fetched on acceptance so the beat after is ready in one cycle
                STREAM:
                    if (beat) begin
                        if (out_index == LAST) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                        end else begin
                            out_index <= next_index;
                            out_pixel <= mem[next_index];
                            out_last  <= next_index == LAST;
                        end
                    end
                default: ;
            endcase
        end

    // bitmap storage is deliberately unreset; the CLEAR sweep zeroes it
    always_ff @(posedge CLOCK_50)
        if (state == CLEAR)
            mem[ptr] <= 1'b0;
        else if (state == WRITE && !clear)
            mem[idx] <= 1'b1;
endmodule

// File: tb/tb_grid_sampler.sv
// tb_grid_sampler: randomized self-checking bench for grid_sampler against a
// division-based bitmap model.
module tb_grid_sampler;
    logic       CLOCK_50 = 1'b0;
    logic       resetn = 1'b0;
    logic       paint = 1'b0, clear = 1'b0, start = 1'b0, out_ready = 1'b0;
    logic [8:0] px = 9'd0, py = 9'd0;
    logic       out_valid, out_pixel, out_last, busy;
    logic [7:0] out_index, cell_count;

    int errors = 0;
    int checks = 0;
    bit ref_map [196];
    int ref_count = 0;
    logic [9:0] cap [$];

    grid_sampler dut (
        .CLOCK_50(CLOCK_50), .resetn(resetn), .paint(paint), .px(px), .py(py),
        .clear(clear), .start(start), .out_ready(out_ready), .out_valid(out_valid),
        .out_pixel(out_pixel), .out_index(out_index), .out_last(out_last),
        .busy(busy), .cell_count(cell_count)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    function automatic bit in_box(int x, int y);
        return x >= 89 && x <= 228 && y >= 33 && y <= 228;
    endfunction

    function automatic int cell_of(int x, int y);
        return ((y - 33) / 14) * 14 + (x - 89) / 10;
    endfunction

    function automatic int lat_of(int x, int y);
        int c = (x - 89) / 10;
        int r = (y - 33) / 14;
        return (c > r ? c : r) + 3;
    endfunction

    function automatic void model_clear();
        foreach (ref_map[k]) ref_map[k] = 1'b0;
        ref_count = 0;
    endfunction

    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (busy && cyc < 2000) begin
            @(negedge CLOCK_50);
            cyc++;
        end
    endtask

    task automatic do_paint(input int x, input int y, output int lat);
        @(negedge CLOCK_50);
        paint = 1'b1; px = 9'(x); py = 9'(y);
        @(negedge CLOCK_50);
        paint = 1'b0;
        lat = 1;
        while (busy && lat < 100) begin
            @(negedge CLOCK_50);
            lat++;
        end
        if (in_box(x, y) && !ref_map[cell_of(x, y)]) begin
            ref_map[cell_of(x, y)] = 1'b1;
            ref_count++;
        end
    endtask

    task automatic do_clear();
        int cyc;
        @(negedge CLOCK_50);
        clear = 1'b1;
        @(negedge CLOCK_50);
        clear = 1'b0;
        wait_idle(cyc);
        model_clear();
    endtask

    // mode 0: always ready, 1: ready toggles 1,0,..., 2: random ready
    task automatic run_stream(input int mode, output int hold_bad);
        int cyc = 0;
        bit done = 1'b0, held = 1'b0;
        logic [7:0] hi = 8'd0;
        logic hp = 1'b0;
        cap.delete();
        hold_bad = 0;
        @(negedge CLOCK_50);
        start = 1'b1;
        @(negedge CLOCK_50);
        start = 1'b0;
        while (!done && cyc < 2000) begin
            if (held && (!out_valid || out_index !== hi || out_pixel !== hp)) hold_bad++;
            out_ready = mode == 0 ? 1'b1 : mode == 1 ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
            held = out_valid && !out_ready;
            hi = out_index;
            hp = out_pixel;
            if (out_valid && out_ready) begin
                cap.push_back({out_last, out_pixel, out_index});
                done = out_last;
            end
            @(negedge CLOCK_50);
            cyc++;
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        int cyc, hb;
        logic [9:0] exp;
        repeat (2) @(negedge CLOCK_50);
        checks++; if ({busy, out_valid, out_last, out_pixel} !== 4'b1000) begin errors++; $display("FAIL reset_flags: got busy/valid/last/pix=%b want 1000", {busy, out_valid, out_last, out_pixel}); end
        checks++; if (out_index !== 8'd0 || cell_count !== 8'd0) begin errors++; $display("FAIL reset_counts: got index=%0d count=%0d want 0 0", out_index, cell_count); end
        resetn = 1'b1;
        wait_idle(cyc);
        checks++; if (cyc != 196) begin errors++; $display("FAIL reset_sweep: got %0d busy cycles want 196", cyc); end
        model_clear();
        run_stream(0, hb);
        checks++; if (cap.size() != 196) begin errors++; $display("FAIL reset_stream_len: got %0d beats want 196", cap.size()); end
        for (int k = 0; k < cap.size() && k < 196; k++) begin
            exp = {k == 195, ref_map[k], 8'(k)};
            checks++; if (cap[k] !== exp) begin errors++; $display("FAIL reset_beat%0d: got last/pix/idx=%b want %b", k, cap[k], exp); end
        end
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset_stream_end: got valid=%b busy=%b want 0 0", out_valid, busy); end
    endtask

    task automatic test_corners();
        int lat;
        do_paint(89, 33, lat);
        checks++; if (lat != 3) begin errors++; $display("FAIL corner0_latency: got %0d want 3", lat); end
        checks++; if (cell_count !== 8'd1) begin errors++; $display("FAIL corner0_count: got %0d want 1", cell_count); end
        do_paint(228, 228, lat);
        checks++; if (lat != 16) begin errors++; $display("FAIL corner195_latency: got %0d want 16", lat); end
        checks++; if (cell_count !== 8'd2) begin errors++; $display("FAIL corner195_count: got %0d want 2", cell_count); end
    endtask

    task automatic test_ignored();
        int lat;
        int xs [3] = '{88, 229, 150};
        int ys [3] = '{100, 100, 229};
        for (int i = 0; i < 3; i++) begin
            do_paint(xs[i], ys[i], lat);
            checks++; if (lat != 1 || busy !== 1'b0) begin errors++; $display("FAIL ignored_%0d: got busy cycles=%0d busy=%b want 1 0", i, lat, busy); end
        end
        checks++; if (cell_count !== 8'd2) begin errors++; $display("FAIL ignored_count: got %0d want 2", cell_count); end
    endtask

    task automatic test_dedupe_toggle();
        int lat, hb;
        logic [9:0] exp;
        do_clear();
        checks++; if (cell_count !== 8'd0) begin errors++; $display("FAIL dedupe_clear: got %0d want 0", cell_count); end
        for (int i = 0; i < 2; i++) begin
            do_paint(150, 100, lat);
            checks++; if (lat != 9 || cell_count !== 8'd1) begin errors++; $display("FAIL dedupe_paint%0d: got latency=%0d count=%0d want 9 1", i, lat, cell_count); end
        end
        run_stream(1, hb);
        checks++; if (cap.size() != 196) begin errors++; $display("FAIL toggle_stream_len: got %0d beats want 196", cap.size()); end
        for (int k = 0; k < cap.size() && k < 196; k++) begin
            exp = {k == 195, k == 62, 8'(k)};
            checks++; if (cap[k] !== exp) begin errors++; $display("FAIL toggle_beat%0d: got last/pix/idx=%b want %b", k, cap[k], exp); end
        end
        checks++; if (hb != 0) begin errors++; $display("FAIL toggle_hold: got %0d unstable stalls want 0", hb); end
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL toggle_stream_end: got valid=%b busy=%b want 0 0", out_valid, busy); end
    endtask

    task automatic test_random();
        int lat, x, y, hb;
        logic [9:0] exp;
        for (int i = 0; i < 30; i++) begin
            x = $urandom_range(80, 240);
            y = $urandom_range(25, 240);
            do_paint(x, y, lat);
            checks++; if (lat != (in_box(x, y) ? lat_of(x, y) : 1)) begin errors++; $display("FAIL rand_latency(%0d,%0d): got %0d want %0d", x, y, lat, in_box(x, y) ? lat_of(x, y) : 1); end
            checks++; if (cell_count !== 8'(ref_count)) begin errors++; $display("FAIL rand_count(%0d,%0d): got %0d want %0d", x, y, cell_count, ref_count); end
        end
        run_stream(2, hb);
        checks++; if (cap.size() != 196) begin errors++; $display("FAIL rand_stream_len: got %0d beats want 196", cap.size()); end
        for (int k = 0; k < cap.size() && k < 196; k++) begin
            exp = {k == 195, ref_map[k], 8'(k)};
            checks++; if (cap[k] !== exp) begin errors++; $display("FAIL rand_beat%0d: got last/pix/idx=%b want %b", k, cap[k], exp); end
        end
        checks++; if (hb != 0) begin errors++; $display("FAIL rand_hold: got %0d unstable stalls want 0", hb); end
    endtask

    task automatic test_abort_clear();
        int cyc, hb;
        logic [9:0] exp;
        out_ready = 1'b1;
        @(negedge CLOCK_50);
        start = 1'b1;
        @(negedge CLOCK_50);
        start = 1'b0;
        cyc = 0;
        while (!(out_valid && out_index == 8'd50) && cyc < 500) begin
            @(negedge CLOCK_50);
            cyc++;
        end
        checks++; if (cyc != 50) begin errors++; $display("FAIL abort_reach50: got %0d cycles want 50", cyc); end
        clear = 1'b1;
        @(negedge CLOCK_50);
        clear = 1'b0;
        out_ready = 1'b0;
        checks++; if ({out_valid, out_last, busy} !== 3'b001) begin errors++; $display("FAIL abort_valid: got valid/last/busy=%b want 001", {out_valid, out_last, busy}); end
        checks++; if (cell_count !== 8'd0) begin errors++; $display("FAIL abort_count: got %0d want 0", cell_count); end
        wait_idle(cyc);
        checks++; if (cyc != 196) begin errors++; $display("FAIL abort_sweep: got %0d busy cycles want 196", cyc); end
        model_clear();
        run_stream(0, hb);
        checks++; if (cap.size() != 196) begin errors++; $display("FAIL abort_stream_len: got %0d beats want 196", cap.size()); end
        for (int k = 0; k < cap.size() && k < 196; k++) begin
            exp = {k == 195, 1'b0, 8'(k)};
            checks++; if (cap[k] !== exp) begin errors++; $display("FAIL abort_beat%0d: got last/pix/idx=%b want %b", k, cap[k], exp); end
        end
    endtask

    task automatic test_priority();
        int lat, cyc, hb;
        logic [9:0] exp;
        do_paint(150, 100, lat);
        checks++; if (cell_count !== 8'd1) begin errors++; $display("FAIL prio_setup: got %0d want 1", cell_count); end
        @(negedge CLOCK_50);
        clear = 1'b1; start = 1'b1; paint = 1'b1; px = 9'd228; py = 9'd228;
        @(negedge CLOCK_50);
        clear = 1'b0; start = 1'b0; paint = 1'b0;
        checks++; if ({busy, out_valid} !== 2'b10 || cell_count !== 8'd0) begin errors++; $display("FAIL prio_clear_wins: got busy/valid=%b count=%0d want 10 0", {busy, out_valid}, cell_count); end
        model_clear();
        repeat (4) @(negedge CLOCK_50);
        start = 1'b1; paint = 1'b1; px = 9'd89; py = 9'd33;
        @(negedge CLOCK_50);
        start = 1'b0; paint = 1'b0;
        repeat (4) @(negedge CLOCK_50);
        clear = 1'b1;
        @(negedge CLOCK_50);
        clear = 1'b0;
        wait_idle(cyc);
        checks++; if (cyc != 196) begin errors++; $display("FAIL prio_sweep_restart: got %0d busy cycles want 196", cyc); end
        checks++; if (out_valid !== 1'b0 || cell_count !== 8'd0) begin errors++; $display("FAIL prio_dropped: got valid=%b count=%0d want 0 0", out_valid, cell_count); end
        @(negedge CLOCK_50);
        paint = 1'b1; px = 9'd228; py = 9'd228;
        @(negedge CLOCK_50);
        paint = 1'b0; clear = 1'b1;
        @(negedge CLOCK_50);
        clear = 1'b0;
        wait_idle(cyc);
        checks++; if (cyc != 196 || cell_count !== 8'd0) begin errors++; $display("FAIL prio_clear_in_map: got sweep=%0d count=%0d want 196 0", cyc, cell_count); end
        @(negedge CLOCK_50);
        paint = 1'b1; px = 9'd228; py = 9'd228;
        @(negedge CLOCK_50);
        px = 9'd89; py = 9'd33;
        @(negedge CLOCK_50);
        paint = 1'b0;
        wait_idle(cyc);
        ref_map[195] = 1'b1;
        ref_count = 1;
        checks++; if (cell_count !== 8'd1) begin errors++; $display("FAIL prio_busy_paint: got %0d want 1", cell_count); end
        run_stream(2, hb);
        checks++; if (cap.size() != 196) begin errors++; $display("FAIL prio_stream_len: got %0d beats want 196", cap.size()); end
        for (int k = 0; k < cap.size() && k < 196; k++) begin
            exp = {k == 195, ref_map[k], 8'(k)};
            checks++; if (cap[k] !== exp) begin errors++; $display("FAIL prio_beat%0d: got last/pix/idx=%b want %b", k, cap[k], exp); end
        end
    endtask

    initial begin
        test_reset();
        test_corners();
        test_ignored();
        test_dedupe_toggle();
        test_random();
        test_abort_clear();
        test_priority();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
